// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch grant after STARVE_MAX contested data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state_reg;
  logic [3:0]          streak_reg;
  logic                drop_reg;
  logic                m_req_reg;
  logic                m_we_reg;
  logic [ADDR_W-1:0]   m_addr_reg;
  logic [DATA_W-1:0]   m_wdata_reg;
  logic [STRB_W-1:0]   m_wstrb_reg;
  logic [DATA_W-1:0]   i_rdata_reg;
  logic [DATA_W-1:0]   d_rdata_reg;

  logic i_eff;
  logic ack_i;
  logic ack_d;
  logic d_wins;

  assign i_eff  = i_req & ~i_flush;
  assign d_wins = d_req & (~i_eff | (streak_reg < 4'(STARVE_MAX)));

  // Completion strobes are combinational so the requester sees them in the ack cycle.
  assign ack_i = rst & (state_reg == BUSY_I) & m_ack;
  assign ack_d = rst & (state_reg == BUSY_D) & m_ack;

  assign i_done  = ack_i & ~drop_reg & ~i_flush;
  assign d_done  = ack_d;
  assign i_rdata = ack_i ? m_rdata : i_rdata_reg;
  assign d_rdata = ack_d ? m_rdata : d_rdata_reg;

  assign m_req   = m_req_reg;
  assign m_we    = m_we_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign m_wstrb = m_wstrb_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      streak_reg  <= '0;
      drop_reg    <= 1'b0;
      m_req_reg   <= 1'b0;
      m_we_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      m_wstrb_reg <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (d_wins) begin
            state_reg   <= BUSY_D;
            m_req_reg   <= 1'b1;
            m_we_reg    <= d_we;
            m_addr_reg  <= d_addr;
            m_wdata_reg <= d_wdata;
            m_wstrb_reg <= d_wstrb;
            // Only a contested data grant counts towards fetch starvation.
            if (i_eff) streak_reg <= streak_reg + 4'd1;
          end else if (i_eff) begin
            state_reg   <= BUSY_I;
            m_req_reg   <= 1'b1;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= i_addr;
            m_wdata_reg <= '0;
            m_wstrb_reg <= '0;
            streak_reg  <= '0;
          end
        end
        BUSY_I: begin
          if (m_ack) begin
            state_reg   <= IDLE;
            m_req_reg   <= 1'b0;
            drop_reg    <= 1'b0;
            i_rdata_reg <= m_rdata;
          end else if (i_flush) begin
            // The bus cycle still runs to completion; only the response is discarded.
            drop_reg <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            state_reg   <= IDLE;
            m_req_reg   <= 1'b0;
            d_rdata_reg <= m_rdata;
          end
        end
        default: begin
          state_reg <= IDLE;
          m_req_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: reset, fetch, write, starvation, flush, mid-op reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_done;
  logic [63:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wstrb;
  logic        m_req, m_we, m_ack;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle; sample at the falling edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  string order;
  string seen;

  initial begin
    rst = 1'b0; i_req = 1'b1; i_flush = 1'b0; i_addr = 64'h8000_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0; d_wdata = 64'h0; d_wstrb = 8'h0;
    m_ack = 1'b0; m_rdata = 64'h0;

    // Reset held for three cycles with both requesters asking.
    for (int k = 0; k < 3; k++) begin
      cyc(); settle();
      chk($sformatf("rst_m_req%0d", k), m_req, 1'b0);
      chk($sformatf("rst_i_done%0d", k), i_done, 1'b0);
      chk($sformatf("rst_d_done%0d", k), d_done, 1'b0);
    end
    chk("rst_m_addr", m_addr, 64'h0);

    // Release with fetch only; grant decided in this IDLE cycle.
    cyc(); rst = 1'b1; d_req = 1'b0; settle();
    chk("idle_m_req", m_req, 1'b0);
    cyc(); settle();
    chk("fetch_m_req", m_req, 1'b1);
    chk("fetch_m_addr", m_addr, 64'h8000_0000);
    chk("fetch_m_wstrb", m_wstrb, 8'h00);
    chk("fetch_m_we", m_we, 1'b0);
    chk("fetch_wait_i_done", i_done, 1'b0);
    cyc(); settle();
    chk("fetch_wait2_i_done", i_done, 1'b0);
    cyc(); m_ack = 1'b1; m_rdata = 64'h0000_0013_0000_0093; settle();
    chk("fetch_i_done", i_done, 1'b1);
    chk("fetch_i_rdata", i_rdata, 64'h0000_0013_0000_0093);
    chk("fetch_d_done", d_done, 1'b0);
    cyc(); m_ack = 1'b0; m_rdata = 64'h0; i_req = 1'b0; settle();
    chk("fetch_after_m_req", m_req, 1'b0);
    chk("fetch_after_i_done", i_done, 1'b0);
    chk("fetch_rdata_hold", i_rdata, 64'h0000_0013_0000_0093);

    // Uncontested write.
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h1000; d_wdata = 64'hDEAD_BEEF; d_wstrb = 8'h0F;
    cyc(); m_ack = 1'b1; settle();
    chk("wr_m_req", m_req, 1'b1);
    chk("wr_m_we", m_we, 1'b1);
    chk("wr_m_addr", m_addr, 64'h1000);
    chk("wr_m_wdata", m_wdata, 64'hDEAD_BEEF);
    chk("wr_m_wstrb", m_wstrb, 8'h0F);
    chk("wr_d_done", d_done, 1'b1);
    chk("wr_i_done", i_done, 1'b0);
    cyc(); d_req = 1'b0; d_we = 1'b0; d_wstrb = 8'h0; m_ack = 1'b0; settle();
    chk("wr_after_m_req", m_req, 1'b0);

    // Contention with immediate acks: streak starts at 0 after the fetch.
    i_req = 1'b1; i_addr = 64'h2000; d_req = 1'b1; d_addr = 64'h3000; m_ack = 1'b1;
    order = "DDDDIDD";
    seen = "";
    for (int k = 0; k < 7; k++) begin
      cyc(); settle();
      if (d_done && !i_done)      seen = {seen, "D"};
      else if (i_done && !d_done) seen = {seen, "I"};
      else                        seen = {seen, "x"};
      cyc();
    end
    checks++;
    assert (seen == order) else begin
      errors++;
      $error("FAIL grant_order: got=%s expected=%s", seen, order);
    end
    i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;

    // Flush in IDLE blocks fetch arbitration for that cycle only.
    cyc(); i_req = 1'b1; i_flush = 1'b1; i_addr = 64'h4000; settle();
    cyc(); i_flush = 1'b0; settle();
    chk("idle_flush_m_req", m_req, 1'b0);
    cyc(); settle();
    chk("idle_flush_then_m_req", m_req, 1'b1);
    chk("idle_flush_then_m_addr", m_addr, 64'h4000);

    // Flush during BUSY_I with ack three cycles later.
    i_flush = 1'b1; settle();
    chk("flush_i_done", i_done, 1'b0);
    cyc(); i_flush = 1'b0; i_req = 1'b0; settle();
    chk("flush_hold1_m_req", m_req, 1'b1);
    cyc(); settle();
    chk("flush_hold2_m_req", m_req, 1'b1);
    cyc(); m_ack = 1'b1; m_rdata = 64'h55; settle();
    chk("flush_ack_m_req", m_req, 1'b1);
    chk("flush_ack_i_done", i_done, 1'b0);
    cyc(); m_ack = 1'b0; i_req = 1'b1; i_addr = 64'h5000; settle();
    chk("flush_after_m_req", m_req, 1'b0);
    cyc(); m_ack = 1'b1; m_rdata = 64'h66; settle();
    chk("refetch_m_addr", m_addr, 64'h5000);
    chk("refetch_i_done", i_done, 1'b1);
    chk("refetch_i_rdata", i_rdata, 64'h66);

    // Flush arriving together with the ack suppresses i_done.
    cyc(); m_ack = 1'b0; i_addr = 64'h5008; settle();
    cyc(); m_ack = 1'b1; m_rdata = 64'h88; i_flush = 1'b1; settle();
    chk("flush_same_m_req", m_req, 1'b1);
    chk("flush_same_i_done", i_done, 1'b0);
    cyc(); m_ack = 1'b0; i_flush = 1'b0; i_req = 1'b0; settle();
    chk("flush_same_after_m_req", m_req, 1'b0);

    // Reset in the middle of a data read.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h6000;
    cyc(); settle();
    chk("midrst_busy_m_req", m_req, 1'b1);
    rst = 1'b0;
    settle();
    cyc(); settle();
    chk("midrst_m_req", m_req, 1'b0);
    chk("midrst_d_done", d_done, 1'b0);
    rst = 1'b1;
    cyc(); m_ack = 1'b1; m_rdata = 64'h77; settle();
    chk("midrst_regrant_m_addr", m_addr, 64'h6000);
    chk("midrst_regrant_d_done", d_done, 1'b1);
    chk("midrst_regrant_d_rdata", d_rdata, 64'h77);
    cyc(); m_ack = 1'b0; d_req = 1'b0; m_rdata = 64'h0; settle();
    chk("midrst_end_m_req", m_req, 1'b0);
    chk("midrst_end_d_done", d_done, 1'b0);
    chk("midrst_rdata_hold", d_rdata, 64'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch requester (ibus side) and the data-access requester (dbus side) of the dual-issue core.
- Sits between the fetch/MM-stage bus masters and the memory/cache port. It serialises requests with one transaction in flight at a time.
- Data requests win by default. A starvation counter guarantees forward progress for instruction fetch.
- Fetch responses can be cancelled by a pipeline flush without aborting the bus cycle.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, data width of all ports
STARVE_MAX, 4, consecutive contested data grants after which fetch is forced; legal range 1..15

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk
i_req  in  1  fetch request; held high until i_done or i_flush
i_addr  in  ADDR_W  fetch address; stable while i_req high
i_flush  in  1  cancel current/pending fetch (flush of IF/ID)
i_done  out  1  fetch response valid, one-cycle pulse
i_rdata  out  DATA_W  fetch read data, valid with i_done
d_req  in  1  data request; held high until d_done
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_wstrb  in  DATA_W/8  byte write strobes
d_done  out  1  data response valid, one-cycle pulse
d_rdata  out  DATA_W  load data, valid with d_done
m_req  out  1  memory request, held until m_ack
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_wstrb  out  DATA_W/8  memory strobes; forced 0 for fetches
m_ack  in  1  memory completes current request; ignored when m_req=0
m_rdata  in  DATA_W  memory read data, valid with m_ack

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, streak=0, drop=0. All outputs are 0: m_req, m_we, m_addr, m_wdata, m_wstrb, i_done, d_done, i_rdata, d_rdata.
- Reset mid-transaction abandons it. The memory side must tolerate m_req dropping.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, evaluated each cycle, using i_eff = i_req & ~i_flush:
  - d_req & ~i_eff -> BUSY_D.
  - i_eff & ~d_req -> BUSY_I.
  - both, streak < STARVE_MAX -> BUSY_D, streak++.
  - both, streak == STARVE_MAX -> BUSY_I.
  - neither -> stay IDLE.
- Any BUSY_I entry clears streak. A BUSY_D entry without contention leaves streak unchanged.
- On entering BUSY, register m_addr/m_we/m_wdata/m_wstrb from the winner. For a fetch: m_we=0, m_wstrb=0, m_wdata=0.
- m_req=1 in BUSY states. Fields are stable until m_ack.
- BUSY_x with m_ack=1:
  - Pulse x_done=1 in the same cycle.
  - x_rdata = m_rdata in that cycle; rdata holds its last value otherwise.
  - m_req drops next cycle; next state is IDLE.
- BUSY_x with m_ack=0: stay.
- Latency: grant decided in cycle N; m_req=1 from N+1; earliest done at N+1 (m_ack same cycle); IDLE at N+2. Minimum 2 cycles per transfer.
- Requesters sample done and drop or replace req by the IDLE cycle, so no double grant is possible.
- Flush during BUSY_I (i_flush=1 any cycle before or with m_ack):
  - Set drop=1. The bus cycle continues to completion.
  - On m_ack, i_done is suppressed (0) and drop is cleared.
- i_flush in IDLE blocks fetch arbitration that cycle only.
- i_flush in BUSY_D has no effect.
- d_done is never suppressed.
- Simultaneous m_ack and i_flush in BUSY_I: i_done=0.
- rst has priority over every event.
- Outputs are registered except i_done/d_done/x_rdata, which are combinational from state, m_ack and m_rdata.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_req=d_req=1 -> m_req=0, i_done=d_done=0 throughout. Release, with i_req=1 only, i_addr=0x8000_0000 -> m_req=1, m_addr=0x8000_0000, m_wstrb=0 one cycle later.
- Single fetch, m_ack 2 cycles after m_req, m_rdata=0x0000_0013_0000_0093 -> i_done pulses once with i_rdata equal to that value; m_req low next cycle.
- Write: d_we=1, d_addr=0x1000, d_wdata=0xDEAD_BEEF, d_wstrb=0x0F -> m_we=1 with exact fields, d_done=1 on m_ack; i_done stays 0.
- Contention, STARVE_MAX=4: i_req and d_req held high, memory acks immediately, each d_done followed by a fresh d_req -> grant order D,D,D,D,I,D,...
- Flush: fetch granted, i_flush=1 for one cycle while m_ack=0, ack 3 cycles later -> m_req stays high until ack, i_done=0 at ack; the next fetch, with i_flush low, completes normally with i_done=1.
- Mid-op reset: rst=0 during BUSY_D before m_ack -> next cycle m_req=0, d_done=0, state IDLE. After release with d_req=1, the request is re-granted and completes on m_ack.
